fp_adder_32bit: RTL and testbench

Single-precision (IEEE 754 binary32) floating-point adder used in the accumulate stage of the floating-point matrix multiplier. It takes two 32-bit operands and returns their rounded sum plus an overflow flag. Inputs are sampled every cycle; the result and flag are registered, so each result appears one clock after its operands.

---
 rtl/fp32_pkg.sv | 33 +++
 rtl/lzc_28.sv | 15 +
 rtl/fp_adder_32bit.sv | 121 ++++++++++++
 tb/tb_fp_adder_32bit.sv | 134 +++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared binary32 field definitions, constants and classification helpers
// for the floating-point adder.
package fp32_pkg;

  localparam int SIGN_W   = 1;
  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;
  localparam int EXP_BIAS = 127;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0]      QNAN    = 32'h7FC00000;
  localparam logic [31:0]      POS_INF = 32'h7F800000;

  typedef struct packed {
    logic [SIGN_W-1:0] sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

  function automatic logic is_nan(input fp32_t v);
    return (v.exp == EXP_MAX) && (v.mant != '0);
  endfunction

  function automatic logic is_inf(input fp32_t v);
    return (v.exp == EXP_MAX) && (v.mant == '0);
  endfunction

  // Subnormals count as zero: they are flushed before any arithmetic.
  function automatic logic is_zero(input fp32_t v);
    return v.exp == '0;
  endfunction

endpackage

// File: rtl/lzc_28.sv
// 28-bit leading-zero counter; an all-zero input reports 28.
module lzc_28 (
  input  logic [27:0] i_val,
  output logic [4:0]  o_cnt
);

  always_comb begin
    o_cnt = 5'd28;
    // Scan upward so the highest set bit determines the final count.
    for (int i = 0; i < 28; i++) begin
      if (i_val[i]) o_cnt = 5'(27 - i);
    end
  end

endmodule

// File: rtl/fp_adder_32bit.sv
// IEEE 754 binary32 adder, round-to-nearest-even, flush-to-zero, with a single
// output register (one cycle latency, one result per cycle).
module fp_adder_32bit
  import fp32_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_res,
  output logic        overflow
);

  fp32_t       a, b, l, s;
  logic        swap;
  logic [7:0]  diff;
  logic [26:0] ext_s, shifted_s, lost_mask, aligned_s;
  logic        sticky;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic [4:0]  sh;
  logic [26:0] norm;
  logic signed [9:0] exp_n, exp_f;
  logic        rnd;
  logic [24:0] mant_r;
  logic [22:0] mant_f;
  logic [31:0] res_d, res_q;
  logic        ovf_d, ovf_q;

  assign a = i_a;
  assign b = i_b;

  // Order operands by magnitude, align the smaller one and add/subtract.
  always_comb begin
    swap      = {b.exp, b.mant} > {a.exp, a.mant};
    l         = swap ? b : a;
    s         = swap ? a : b;
    diff      = l.exp - s.exp;
    ext_s     = {1'b1, s.mant, 3'b000};
    shifted_s = '0;
    lost_mask = '0;
    sticky    = 1'b0;
    if (diff >= 8'd27) begin
      aligned_s = {26'd0, 1'b1};
    end else begin
      shifted_s = ext_s >> diff;
      lost_mask = (27'd1 << diff) - 27'd1;
      sticky    = |(ext_s & lost_mask);
      aligned_s = shifted_s | {26'd0, sticky};
    end
    if (l.sign == s.sign) sum = {1'b0, 1'b1, l.mant, 3'b000} + {1'b0, aligned_s};
    else                  sum = {1'b0, 1'b1, l.mant, 3'b000} - {1'b0, aligned_s};
  end

  lzc_28 u_lzc (
    .i_val (sum),
    .o_cnt (lz)
  );

  // Normalize, round, then resolve specials and range limits.
  always_comb begin
    sh = 5'd0;
    if (sum[27]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      exp_n = $signed({2'b00, l.exp}) + 10'sd1;
    end else begin
      sh    = lz - 5'd1;
      norm  = 27'(sum << sh);
      exp_n = $signed({2'b00, l.exp}) - $signed({5'd0, sh});
    end
    rnd    = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r = {1'b0, norm[26:3]} + {24'd0, rnd};
    if (mant_r[24]) begin
      mant_f = mant_r[23:1];
      exp_f  = exp_n + 10'sd1;
    end else begin
      mant_f = mant_r[22:0];
      exp_f  = exp_n;
    end

    ovf_d = 1'b0;
    if (is_nan(a) || is_nan(b)) begin
      res_d = QNAN;
    end else if (is_inf(a) && is_inf(b) && (a.sign != b.sign)) begin
      res_d = QNAN;
    end else if (is_inf(a)) begin
      res_d = a;
    end else if (is_inf(b)) begin
      res_d = b;
    end else if (is_zero(a) && is_zero(b)) begin
      res_d = {a.sign & b.sign, 31'd0};
    end else if (is_zero(a)) begin
      res_d = b;
    end else if (is_zero(b)) begin
      res_d = a;
    end else if (sum == '0) begin
      res_d = 32'h0000_0000;
    end else if (exp_f >= 10'sd255) begin
      res_d = {l.sign, POS_INF[30:0]};
      ovf_d = 1'b1;
    end else if (exp_f <= 10'sd0) begin
      res_d = {l.sign, 31'd0};
    end else begin
      res_d = {l.sign, exp_f[7:0], mant_f};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      res_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      res_q <= res_d;
      ovf_q <= ovf_d;
    end
  end

  assign o_res    = res_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_fp_adder_32bit.sv
// Directed-vector bench for fp_adder_32bit with a queue-based scoreboard.
module tb_fp_adder_32bit;

  logic        clk;
  logic        rst;
  logic [31:0] a, b;
  logic [31:0] res;
  logic        ovf;

  logic        drive_valid;
  logic        pend;
  logic [32:0] exp_q[$];
  int          n_tests;
  int          n_fail;

  fp_adder_32bit dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_a      (a),
    .i_b      (b),
    .o_res    (res),
    .overflow (ovf)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout res=%08h", res);
    $fatal(1, "timeout");
  end

  // Driver: operands change 1 time unit after a rising edge and are
  // sampled at the next one, so each call is one operation per cycle.
  task automatic issue(input logic [31:0] va, input logic [31:0] vb,
                       input logic vrst, input logic [31:0] eres,
                       input logic eovf);
    @(posedge clk);
    #1;
    a           = va;
    b           = vb;
    rst         = vrst;
    drive_valid = 1'b1;
    exp_q.push_back({eovf, eres});
  endtask

  // Monitor: a result is due after the edge that sampled a driven pair.
  always @(posedge clk) pend <= drive_valid;

  always @(negedge clk) begin
    logic [32:0] e;
    if (pend) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result got res=%08h ovf=%0b, queue empty", res, ovf);
      end else begin
        e = exp_q.pop_front();
        if ({ovf, res} !== e) begin
          n_fail++;
          $display("FAIL result got res=%08h ovf=%0b expected res=%08h ovf=%0b",
                   res, ovf, e[31:0], e[32]);
        end
      end
    end
  end

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    drive_valid = 1'b0;
    pend        = 1'b0;
    rst         = 1'b1;
    a           = 32'h4000_0000;
    b           = 32'h4040_0000;

    // Reset held for two cycles with live operands: output must stay zero.
    issue(32'h4000_0000, 32'h4040_0000, 1'b1, 32'h0000_0000, 1'b0);
    issue(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b1, 32'h0000_0000, 1'b0);

    // Basic arithmetic
    issue(32'h4000_0000, 32'h4040_0000, 1'b0, 32'h40A0_0000, 1'b0);
    issue(32'hC000_0000, 32'h4040_0000, 1'b0, 32'h3F80_0000, 1'b0);
    issue(32'h3FC0_0000, 32'hC088_0000, 1'b0, 32'hC030_0000, 1'b0);
    issue(32'h4123_D70A, 32'hC088_0000, 1'b0, 32'h40BF_AE14, 1'b0);
    issue(32'h3089_705F, 32'hC12E_38E4, 1'b0, 32'hC12E_38E4, 1'b0);
    issue(32'h0000_0000, 32'h42F6_E979, 1'b0, 32'h42F6_E979, 1'b0);

    // Special operands
    issue(32'h7F80_0000, 32'h4000_0000, 1'b0, 32'h7F80_0000, 1'b0);
    issue(32'h7F80_0000, 32'hC000_0000, 1'b0, 32'h7F80_0000, 1'b0);
    issue(32'h7F80_0000, 32'h0000_0000, 1'b0, 32'h7F80_0000, 1'b0);
    issue(32'h4000_0000, 32'hFF80_0000, 1'b0, 32'hFF80_0000, 1'b0);
    issue(32'h7FC0_0000, 32'h4000_0000, 1'b0, 32'h7FC0_0000, 1'b0);
    issue(32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000, 1'b0);
    issue(32'h7F80_0000, 32'h7F80_0000, 1'b0, 32'h7F80_0000, 1'b0);
    issue(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0);
    issue(32'h8000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0);
    issue(32'h0000_0001, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 1'b0);

    // Overflow, then an ordinary sum must clear the flag
    issue(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 1'b1);
    issue(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0);
    issue(32'hFF7F_FFFF, 32'hFF7F_FFFF, 1'b0, 32'hFF80_0000, 1'b1);

    // Cancellation, rounding, underflow
    issue(32'h3F80_0000, 32'hBF80_0000, 1'b0, 32'h0000_0000, 1'b0);
    issue(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 1'b0);
    issue(32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002, 1'b0);
    issue(32'h0080_0001, 32'h8080_0000, 1'b0, 32'h0000_0000, 1'b0);

    // Reset mid-stream overrides operands; the following edge resumes
    issue(32'h4000_0000, 32'h4040_0000, 1'b1, 32'h0000_0000, 1'b0);
    issue(32'hC000_0000, 32'h4040_0000, 1'b0, 32'h3F80_0000, 1'b0);

    @(posedge clk);
    #1;
    drive_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending entries, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
